// File: rtl/ise_result_collector.sv
// ise_result_collector: buffers the sorted ISE results, checks them,
// counts colours, then replays the list to the host over valid/ready.
//
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   in_valid       : one ISE result per high cycle (never stalled)
//   in_color       : colour of result (0=R 1=G 2=B 3=illegal)
//   in_index       : image index of result
//   out_valid      : buffered result presented to host
//   out_ready      : host accepts on out_valid & out_ready
//   out_color      : colour of presented result
//   out_index      : image index of presented result
//   out_last       : presented result is the final entry
//   done           : whole buffer drained, held until reset
//   cnt_r/g/b      : per-colour result counts
//   err_flags      : sticky {overflow, colour 3, order, duplicate}
module ise_result_collector #(
   parameter int IMAGE_NUM = 32,
   parameter int IDX_W     = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [1:0]       in_color,
   input  logic [IDX_W-1:0] in_index,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_color,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic             done,
   output logic [IDX_W:0]   cnt_r,
   output logic [IDX_W:0]   cnt_g,
   output logic [IDX_W:0]   cnt_b,
   output logic [3:0]       err_flags
);

   typedef enum logic [1:0] {
      S_COLLECT,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam logic [IDX_W-1:0] LAST_PTR =
      IDX_W'(IMAGE_NUM - 1);
   localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);
   localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);

   state_e state_q, state_d;

   logic [IDX_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [IMAGE_NUM-1:0] seen_q, seen_d;
   logic [1:0]           prev_color_q, prev_color_d;
   logic [IDX_W:0]       cnt_r_q, cnt_r_d;
   logic [IDX_W:0]       cnt_g_q, cnt_g_d;
   logic [IDX_W:0]       cnt_b_q, cnt_b_d;
   logic [3:0]           err_q, err_d;

   // Entry layout: {colour, index}.
   logic [IDX_W+1:0] mem_q [IMAGE_NUM];
   logic [IDX_W+1:0] rd_data;

   // Control strobes from the output decoder.
   logic wr_en;
   logic rd_en;
   logic ovf;

   logic dup_hit;
   logic ord_hit;
   logic ill_hit;

   // ------------------------------------------------
   // FSM: state register
   // ------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_COLLECT: begin
            if (in_valid && wr_ptr_q == LAST_PTR) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_ready && rd_ptr_q == LAST_PTR) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_COLLECT;
         end
      endcase
   end

   // ------------------------------------------------
   // FSM: output / strobe logic
   // ------------------------------------------------
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      out_valid = 1'b0;
      out_color = 2'd0;
      out_index = '0;
      out_last  = 1'b0;
      done      = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      ovf       = 1'b0;
      unique case (state_q)
         S_COLLECT: begin
            wr_en = in_valid;
         end
         S_DRAIN: begin
            // Read data is gated so outputs stay 0
            // outside the replay phase.
            out_valid = 1'b1;
            out_color = rd_data[IDX_W+1:IDX_W];
            out_index = rd_data[IDX_W-1:0];
            out_last  = (rd_ptr_q == LAST_PTR);
            rd_en     = out_ready;
            ovf       = in_valid;
         end
         S_DONE: begin
            done = 1'b1;
            ovf  = in_valid;
         end
         default: begin
            ovf = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------
   // Result checks against pre-update state
   // ------------------------------------------------
   assign dup_hit = seen_q[in_index];
   assign ord_hit = (wr_ptr_q != '0) &&
                    (in_color < prev_color_q);
   assign ill_hit = (in_color == 2'd3);

   // ------------------------------------------------
   // Datapath next-state
   // ------------------------------------------------
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      seen_d       = seen_q;
      prev_color_d = prev_color_q;
      cnt_r_d      = cnt_r_q;
      cnt_g_d      = cnt_g_q;
      cnt_b_d      = cnt_b_q;
      err_d        = err_q;

      if (wr_en) begin
         wr_ptr_d         = wr_ptr_q + PTR_ONE;
         seen_d[in_index] = 1'b1;
         prev_color_d     = in_color;
         unique case (in_color)
            2'd0:    cnt_r_d = cnt_r_q + CNT_ONE;
            2'd1:    cnt_g_d = cnt_g_q + CNT_ONE;
            2'd2:    cnt_b_d = cnt_b_q + CNT_ONE;
            default: cnt_r_d = cnt_r_q;
         endcase
         err_d[0] = err_q[0] | dup_hit;
         err_d[1] = err_q[1] | ord_hit;
         err_d[2] = err_q[2] | ill_hit;
      end

      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      // Results arriving after collection are lost.
      if (ovf) begin
         err_d[3] = 1'b1;
      end
   end

   // ------------------------------------------------
   // Datapath registers
   // ------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         seen_q       <= '0;
         prev_color_q <= 2'd0;
         cnt_r_q      <= '0;
         cnt_g_q      <= '0;
         cnt_b_q      <= '0;
         err_q        <= 4'd0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         seen_q       <= seen_d;
         prev_color_q <= prev_color_d;
         cnt_r_q      <= cnt_r_d;
         cnt_g_q      <= cnt_g_d;
         cnt_b_q      <= cnt_b_d;
         err_q        <= err_d;
      end
   end

   // Buffer contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {in_color, in_index};
      end
   end

   assign cnt_r     = cnt_r_q;
   assign cnt_g     = cnt_g_q;
   assign cnt_b     = cnt_b_q;
   assign err_flags = err_q;

endmodule

// File: tb/tb_ise_result_collector.sv
// tb_ise_result_collector: directed bench for ise_result_collector.
// Capture, checks, counts, stalled replay and reset recovery.
module tb_ise_result_collector;

   localparam int N = 32;
   localparam int W = 5;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic [1:0]   in_color;
   logic [W-1:0] in_index;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   out_color;
   logic [W-1:0] out_index;
   logic         out_last;
   logic         done;
   logic [W:0]   cnt_r;
   logic [W:0]   cnt_g;
   logic [W:0]   cnt_b;
   logic [3:0]   err_flags;

   int checks;
   int failures;

   logic [1:0]   exp_c [N];
   logic [W-1:0] exp_i [N];
   logic [1:0]   got_c [N];
   logic [W-1:0] got_i [N];
   logic         got_l [N];
   int           nbeats;
   logic         unstable;
   logic         early_done;

   ise_result_collector #(
      .IMAGE_NUM(N),
      .IDX_W    (W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_color (in_color),
      .in_index (in_index),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_color(out_color),
      .out_index(out_index),
      .out_last (out_last),
      .done     (done),
      .cnt_r    (cnt_r),
      .cnt_g    (cnt_g),
      .cnt_b    (cnt_b),
      .err_flags(err_flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic do_reset();
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_color  = 2'd0;
      in_index  = '0;
      out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic send_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         in_valid = 1'b1;
         in_color = exp_c[i];
         in_index = exp_i[i];
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   // Drives out_ready from a 4-cycle pattern and records
   // every handshake; bounded by max_cyc.
   task automatic drain(input logic [3:0] pat,
                        input int max_cyc);
      logic [W+2:0] cur;
      logic [W+2:0] prev;
      logic         stalled;
      int           cyc;
      nbeats     = 0;
      unstable   = 1'b0;
      early_done = 1'b0;
      stalled    = 1'b0;
      prev       = '0;
      cyc        = 0;
      while (nbeats < N && cyc < max_cyc) begin
         out_ready = pat[cyc % 4];
         #0;
         if (done) early_done = 1'b1;
         if (out_valid) begin
            cur = {out_color, out_index, out_last};
            if (stalled && cur !== prev) unstable = 1'b1;
            prev    = cur;
            stalled = !out_ready;
            if (out_ready) begin
               got_c[nbeats] = out_color;
               got_i[nbeats] = out_index;
               got_l[nbeats] = out_last;
               nbeats++;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      out_ready = 1'b0;
   endtask

   task automatic fill_clean();
      for (int i = 0; i < N; i++) begin
         exp_c[i] = 2'(i / 11);
         exp_i[i] = W'(31 - i);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({out_valid, out_last, done, out_color,
           out_index} !== '0) begin
         failures++;
         $display("FAIL rst_out got v=%b l=%b d=%b c=%0d i=%0d exp all 0",
                  out_valid, out_last, done, out_color, out_index);
      end
      checks++;
      if ({cnt_r, cnt_g, cnt_b, err_flags} !== '0) begin
         failures++;
         $display("FAIL rst_cnt got r=%0d g=%0d b=%0d e=%b exp 0",
                  cnt_r, cnt_g, cnt_b, err_flags);
      end
   endtask

   task automatic test_clean(input string tag);
      fill_clean();
      send_range(0, N - 2);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_early_valid got %b exp 0",
                  tag, out_valid);
      end
      send_range(N - 1, N - 1);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s_first_valid got %b exp 1",
                  tag, out_valid);
      end
      checks++;
      if (cnt_r !== 6'd11 || cnt_g !== 6'd11 ||
          cnt_b !== 6'd10 || err_flags !== 4'b0000) begin
         failures++;
         $display("FAIL %s_counts got r=%0d g=%0d b=%0d e=%b exp 11 11 10 0000",
                  tag, cnt_r, cnt_g, cnt_b, err_flags);
      end
      drain(4'b1111, 100);
      checks++;
      if (nbeats !== N) begin
         failures++;
         $display("FAIL %s_nbeats got %0d exp %0d",
                  tag, nbeats, N);
      end
      for (int b = 0; b < nbeats; b++) begin
         checks++;
         if (got_c[b] !== exp_c[b] || got_i[b] !== exp_i[b] ||
             got_l[b] !== (b == N - 1)) begin
            failures++;
            $display("FAIL %s_beat%0d got c=%0d i=%0d l=%b exp c=%0d i=%0d l=%b",
                     tag, b, got_c[b], got_i[b], got_l[b],
                     exp_c[b], exp_i[b], b == N - 1);
         end
      end
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_done got d=%b v=%b exp d=1 v=0",
                  tag, done, out_valid);
      end
   endtask

   task automatic test_stall();
      do_reset();
      fill_clean();
      send_range(0, N - 1);
      drain(4'b1001, 400);
      checks++;
      if (nbeats !== N) begin
         failures++;
         $display("FAIL stall_nbeats got %0d exp %0d", nbeats, N);
      end
      for (int b = 0; b < nbeats; b++) begin
         checks++;
         if (got_c[b] !== exp_c[b] || got_i[b] !== exp_i[b] ||
             got_l[b] !== (b == N - 1)) begin
            failures++;
            $display("FAIL stall_beat%0d got c=%0d i=%0d l=%b exp c=%0d i=%0d l=%b",
                     b, got_c[b], got_i[b], got_l[b],
                     exp_c[b], exp_i[b], b == N - 1);
         end
      end
      checks++;
      if (unstable !== 1'b0) begin
         failures++;
         $display("FAIL stall_stable got change=%b exp 0", unstable);
      end
      checks++;
      if (early_done !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL stall_done got early=%b done=%b exp 0 1",
                  early_done, done);
      end
   endtask

   task automatic test_dup();
      do_reset();
      fill_clean();
      for (int i = 0; i < N; i++) begin
         exp_i[i] = (i == 8) ? W'(7) : W'(i);
      end
      send_range(0, N - 1);
      checks++;
      if (err_flags !== 4'b0001) begin
         failures++;
         $display("FAIL dup_err got %b exp 0001", err_flags);
      end
      drain(4'b1111, 100);
      checks++;
      if (nbeats !== N || got_i[7] !== 5'd7 ||
          got_i[8] !== 5'd7 || got_i[9] !== 5'd9) begin
         failures++;
         $display("FAIL dup_replay got n=%0d i7=%0d i8=%0d i9=%0d exp 32 7 7 9",
                  nbeats, got_i[7], got_i[8], got_i[9]);
      end
   endtask

   task automatic test_color_err();
      do_reset();
      for (int i = 0; i < N; i++) begin
         exp_i[i] = W'(i);
         exp_c[i] = 2'd1;
      end
      exp_c[0]     = 2'd0;
      exp_c[1]     = 2'd2;
      exp_c[N - 1] = 2'd3;
      send_range(0, N - 1);
      checks++;
      if (err_flags !== 4'b0110) begin
         failures++;
         $display("FAIL col_err got %b exp 0110", err_flags);
      end
      checks++;
      if (cnt_r !== 6'd1 || cnt_g !== 6'd29 ||
          cnt_b !== 6'd1) begin
         failures++;
         $display("FAIL col_cnt got r=%0d g=%0d b=%0d exp 1 29 1",
                  cnt_r, cnt_g, cnt_b);
      end
      drain(4'b1111, 100);
      checks++;
      if (nbeats !== N || got_c[1] !== 2'd2 ||
          got_c[2] !== 2'd1 || got_c[N - 1] !== 2'd3) begin
         failures++;
         $display("FAIL col_replay got n=%0d c1=%0d c2=%0d c31=%0d exp 32 2 1 3",
                  nbeats, got_c[1], got_c[2], got_c[N - 1]);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      fill_clean();
      send_range(0, N - 1);
      in_valid = 1'b1;
      in_color = 2'd0;
      in_index = 5'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (err_flags !== 4'b1000) begin
         failures++;
         $display("FAIL ovf_err got %b exp 1000", err_flags);
      end
      drain(4'b1111, 100);
      checks++;
      if (nbeats !== N) begin
         failures++;
         $display("FAIL ovf_nbeats got %0d exp %0d", nbeats, N);
      end
      for (int b = 0; b < nbeats; b++) begin
         checks++;
         if (got_c[b] !== exp_c[b] || got_i[b] !== exp_i[b]) begin
            failures++;
            $display("FAIL ovf_beat%0d got c=%0d i=%0d exp c=%0d i=%0d",
                     b, got_c[b], got_i[b], exp_c[b], exp_i[b]);
         end
      end
      in_valid = 1'b1;
      in_color = 2'd1;
      in_index = 5'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 ||
          err_flags !== 4'b1000 || cnt_r !== 6'd11 ||
          cnt_g !== 6'd11 || cnt_b !== 6'd10) begin
         failures++;
         $display("FAIL ovf_done got d=%b v=%b e=%b r=%0d g=%0d b=%0d exp 1 0 1000 11 11 10",
                  done, out_valid, err_flags,
                  cnt_r, cnt_g, cnt_b);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         exp_c[i] = 2'd3;
         exp_i[i] = 5'd0;
      end
      send_range(0, 9);
      checks++;
      if (err_flags !== 4'b0101) begin
         failures++;
         $display("FAIL mid_pre got %b exp 0101", err_flags);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      checks++;
      if ({cnt_r, cnt_g, cnt_b, err_flags,
           out_valid, done} !== '0) begin
         failures++;
         $display("FAIL mid_clear got r=%0d g=%0d b=%0d e=%b v=%b d=%b exp 0",
                  cnt_r, cnt_g, cnt_b, err_flags,
                  out_valid, done);
      end
      test_clean("mid");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_color  = 2'd0;
      in_index  = '0;
      out_ready = 1'b0;
      test_reset();
      test_clean("clean");
      test_stall();
      test_dup();
      test_color_err();
      test_overflow();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
